// File: rtl/port_traffic_flush.sv
// port_traffic_flush
//   Quiesce controller between the AFU TX arbiter and the port reset logic.
//   It counts AFU read requests in flight toward the host. On a flush request
//   it closes TX at a packet boundary, then waits for outstanding reads to
//   complete or for a drain timeout, and reports completion.
//
// Ports
//   clk                 clock
//   reset               synchronous, active-high reset
//   i_flush_req         level: quiesce the port
//   i_tx_valid/ready    AFU TX handshake
//   i_tx_last           TX beat is end of packet
//   i_rd_issue          pulse: one read request accepted
//   i_rd_cpl_done       pulse: final completion of one read
//   o_tx_block          upstream must not start a new TX packet
//   o_tx_drained        TX is blocked and no packet is mid-flight
//   o_read_flush_done   quiesce complete; held until i_flush_req drops
//   o_outstanding       in-flight read count
//   o_flush_timeout     sticky: last flush ended by timeout
//   o_cnt_err           sticky: counter underflow or overflow attempt
module port_traffic_flush #(
    parameter int unsigned MAX_OUTSTANDING = 256,
    parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1),
    parameter int unsigned TIMEOUT_CYCLES  = 65536,
    parameter int unsigned TMO_W           = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush_req,
    input  logic             i_tx_valid,
    input  logic             i_tx_ready,
    input  logic             i_tx_last,
    input  logic             i_rd_issue,
    input  logic             i_rd_cpl_done,
    output logic             o_tx_block,
    output logic             o_tx_drained,
    output logic             o_read_flush_done,
    output logic [CNT_W-1:0] o_outstanding,
    output logic             o_flush_timeout,
    output logic             o_cnt_err
);

    typedef enum logic [1:0] {StIdle, StBlock, StDrain, StDone} state_e;

    localparam logic [CNT_W-1:0] CntMax  = CNT_W'(MAX_OUTSTANDING);
    localparam bit               TmoEn   = (TIMEOUT_CYCLES != 0);
    localparam logic [TMO_W-1:0] TmoLast = TmoEn ? TMO_W'(TIMEOUT_CYCLES - 1) : '0;

    state_e           state_q, state_d;
    logic             in_pkt_q, in_pkt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tx_block_q, tx_block_d;
    logic             drained_q, drained_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic             cnt_err_q, cnt_err_d;

    logic beat;
    logic tmo_expired;
    logic active_q, active_d;

    assign beat = i_tx_valid & i_tx_ready;
    // >= rather than == so a long BLOCK phase that overruns the limit still
    // times out as soon as DRAIN is reached.
    assign tmo_expired = TmoEn && (tmo_q >= TmoLast);

    // Packet tracking: a single-beat packet never sets in_pkt.
    always_comb begin
        in_pkt_d = in_pkt_q;
        if (beat) begin
            in_pkt_d = ~i_tx_last;
        end
    end

    // Quiesce FSM
    always_comb begin
        state_d   = state_q;
        timeout_d = timeout_q;
        case (state_q)
            StIdle: begin
                if (i_flush_req) begin
                    state_d   = StBlock;
                    timeout_d = 1'b0;
                end
            end
            StBlock: begin
                if (!i_flush_req) begin
                    state_d = StIdle;
                end else if (!in_pkt_q) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!i_flush_req) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    state_d = StDone;
                end else if (tmo_expired) begin
                    state_d   = StDone;
                    timeout_d = 1'b1;
                end
            end
            StDone: begin
                if (!i_flush_req) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outstanding read counter, active in every state.
    always_comb begin
        cnt_d     = cnt_q;
        cnt_err_d = cnt_err_q;
        if (i_rd_issue && !i_rd_cpl_done) begin
            if (cnt_q == CntMax) begin
                cnt_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (i_rd_cpl_done && !i_rd_issue) begin
            if (cnt_q == '0) begin
                cnt_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
        // Reads abandoned by a timed-out flush will never complete.
        if (state_q == StDone && state_d == StIdle && timeout_q) begin
            cnt_d = '0;
        end
    end

    // Drain timer runs only while staying within BLOCK/DRAIN.
    assign active_q = (state_q == StBlock) || (state_q == StDrain);
    assign active_d = (state_d == StBlock) || (state_d == StDrain);

    always_comb begin
        tmo_d = '0;
        if (active_q && active_d) begin
            tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + TMO_W'(1);
        end
    end

    // Registered outputs
    always_comb begin
        tx_block_d = (state_d != StIdle);
        done_d     = (state_d == StDone);
        drained_d  = (state_q != StIdle) && !in_pkt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            in_pkt_q   <= 1'b0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            tx_block_q <= 1'b0;
            drained_q  <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_pkt_q   <= in_pkt_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            tx_block_q <= tx_block_d;
            drained_q  <= drained_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            cnt_err_q  <= cnt_err_d;
        end
    end

    assign o_tx_block        = tx_block_q;
    assign o_tx_drained      = drained_q;
    assign o_read_flush_done = done_q;
    assign o_outstanding     = cnt_q;
    assign o_flush_timeout   = timeout_q;
    assign o_cnt_err         = cnt_err_q;

endmodule

// File: tb/tb_port_traffic_flush.sv
// tb_port_traffic_flush
//   Directed bench for port_traffic_flush. Stimulus pushes timed expectations
//   into a scoreboard queue; a negedge monitor pops and compares them, and
//   separately checks every rising edge of o_read_flush_done against the
//   cycle at which a done was expected.
module tb_port_traffic_flush;

    localparam int unsigned MaxOut = 8;
    localparam int unsigned TmoCyc = 16;
    localparam int unsigned TmoW   = 17;

    localparam int SelBlock   = 0;
    localparam int SelDrained = 1;
    localparam int SelDone    = 2;
    localparam int SelCnt     = 3;
    localparam int SelTmo     = 4;
    localparam int SelErr     = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_flush_req, i_tx_valid, i_tx_ready, i_tx_last, i_rd_issue, i_rd_cpl_done;
    logic       o_tx_block, o_tx_drained, o_read_flush_done, o_flush_timeout, o_cnt_err;
    logic [3:0] o_outstanding;

    always #5 clk = ~clk;

    port_traffic_flush #(
        .MAX_OUTSTANDING(MaxOut),
        .TIMEOUT_CYCLES (TmoCyc),
        .TMO_W          (TmoW)
    ) u_dut (
        .clk              (clk),
        .reset            (reset),
        .i_flush_req      (i_flush_req),
        .i_tx_valid       (i_tx_valid),
        .i_tx_ready       (i_tx_ready),
        .i_tx_last        (i_tx_last),
        .i_rd_issue       (i_rd_issue),
        .i_rd_cpl_done    (i_rd_cpl_done),
        .o_tx_block       (o_tx_block),
        .o_tx_drained     (o_tx_drained),
        .o_read_flush_done(o_read_flush_done),
        .o_outstanding    (o_outstanding),
        .o_flush_timeout  (o_flush_timeout),
        .o_cnt_err        (o_cnt_err)
    );

    typedef struct {
        int    cyc;
        int    sel;
        int    val;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic prev_done = 1'b0;
    int   mon_i;
    int   mon_act;
    int   mon_exp;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sample(input int sel);
        case (sel)
            SelBlock:   return int'(o_tx_block);
            SelDrained: return int'(o_tx_drained);
            SelDone:    return int'(o_read_flush_done);
            SelCnt:     return int'(o_outstanding);
            SelTmo:     return int'(o_flush_timeout);
            default:    return int'(o_cnt_err);
        endcase
    endfunction

    // Monitor
    always @(negedge clk) begin
        mon_i = 0;
        while (mon_i < exp_q.size()) begin
            if (exp_q[mon_i].cyc < cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d never compared (now %0d)",
                         exp_q[mon_i].name, exp_q[mon_i].cyc, cyc);
                exp_q.delete(mon_i);
            end else if (exp_q[mon_i].cyc == cyc) begin
                checks++;
                mon_act = sample(exp_q[mon_i].sel);
                if (mon_act != exp_q[mon_i].val) begin
                    errors++;
                    $display("FAIL %s @cycle %0d: got %0d, want %0d",
                             exp_q[mon_i].name, cyc, mon_act, exp_q[mon_i].val);
                end
                exp_q.delete(mon_i);
            end else begin
                mon_i++;
            end
        end
        if (o_read_flush_done === 1'b1 && prev_done !== 1'b1) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL done_rise: unexpected done at cycle %0d, want none", cyc);
            end else begin
                mon_exp = done_q.pop_front();
                if (mon_exp != cyc) begin
                    errors++;
                    $display("FAIL done_rise: got done at cycle %0d, want cycle %0d",
                             cyc, mon_exp);
                end
            end
        end
        prev_done = o_read_flush_done;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_at(input int dc, input int sel, input int val, input string nm);
        exp_t e;
        e.cyc  = cyc + dc;
        e.sel  = sel;
        e.val  = val;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic exp_done(input int dc);
        done_q.push_back(cyc + dc);
    endtask

    task automatic exp_all_zero(input int dc, input string nm);
        for (int s = 0; s < 6; s++) begin
            exp_at(dc, s, 0, $sformatf("%s_%0d", nm, s));
        end
    endtask

    initial begin
        reset         = 1'b1;
        i_flush_req   = 1'b0;
        i_tx_valid    = 1'b0;
        i_tx_ready    = 1'b0;
        i_tx_last     = 1'b0;
        i_rd_issue    = 1'b0;
        i_rd_cpl_done = 1'b0;
        step(3);
        exp_all_zero(0, "reset_val");
        step(1);
        reset = 1'b0;
        step(2);

        // Idle flush: block +1, drained +2, done +3
        i_flush_req = 1'b1;
        exp_at(0, SelBlock, 0, "idle_block_pre");
        exp_at(1, SelBlock, 1, "idle_block");
        exp_at(1, SelDone, 0, "idle_done_early1");
        exp_at(2, SelDrained, 1, "idle_drained");
        exp_at(2, SelDone, 0, "idle_done_early2");
        exp_at(3, SelDone, 1, "idle_done");
        exp_at(5, SelDone, 1, "idle_done_hold");
        exp_done(3);
        step(6);
        i_flush_req = 1'b0;
        exp_at(1, SelDone, 0, "idle_done_drop");
        exp_at(1, SelBlock, 0, "idle_block_drop");
        exp_at(2, SelDrained, 0, "idle_drained_drop");
        step(4);

        // Packet boundary: flush raised on beat 2 of a 4-beat packet
        i_tx_valid = 1'b1;
        i_tx_ready = 1'b1;
        i_tx_last  = 1'b0;
        exp_at(2, SelBlock, 1, "pkt_block");
        exp_at(3, SelDrained, 0, "pkt_drained_mid1");
        exp_at(4, SelDrained, 0, "pkt_drained_mid2");
        exp_at(5, SelDrained, 1, "pkt_drained");
        exp_at(5, SelDone, 0, "pkt_done_early");
        exp_at(6, SelDone, 1, "pkt_done");
        exp_done(6);
        step(1);
        i_flush_req = 1'b1;
        step(2);
        i_tx_last = 1'b1;
        step(1);
        i_tx_valid = 1'b0;
        i_tx_ready = 1'b0;
        i_tx_last  = 1'b0;
        step(3);
        i_flush_req = 1'b0;
        exp_at(1, SelDone, 0, "pkt_done_drop");
        exp_at(1, SelBlock, 0, "pkt_block_drop");
        step(3);

        // Drain: 3 reads outstanding, done one cycle after count reaches 0
        i_rd_issue = 1'b1;
        step(3);
        i_rd_issue  = 1'b0;
        i_flush_req = 1'b1;
        exp_at(0, SelCnt, 3, "drain_cnt3");
        exp_at(5, SelDone, 0, "drain_wait1");
        exp_at(6, SelCnt, 1, "drain_cnt1");
        exp_at(8, SelCnt, 0, "drain_cnt0");
        exp_at(8, SelDone, 0, "drain_wait0");
        exp_at(9, SelDone, 1, "drain_done");
        exp_done(9);
        step(3);
        for (int k = 0; k < 3; k++) begin
            i_rd_cpl_done = 1'b1;
            step(1);
            i_rd_cpl_done = 1'b0;
            step(1);
        end
        step(2);
        i_flush_req = 1'b0;
        exp_at(1, SelDone, 0, "drain_done_drop");
        step(3);

        // Simultaneous issue/cpl and underflow
        i_rd_issue = 1'b1;
        exp_at(5, SelCnt, 5, "sim_cnt5");
        step(5);
        i_rd_cpl_done = 1'b1;
        exp_at(1, SelCnt, 5, "sim_issue_cpl");
        step(1);
        i_rd_issue = 1'b0;
        exp_at(1, SelCnt, 4, "cpl_dec");
        exp_at(1, SelErr, 0, "cpl_no_err");
        step(5);
        exp_at(0, SelCnt, 0, "cnt_zero");
        exp_at(0, SelErr, 0, "cnt_zero_no_err");
        exp_at(1, SelCnt, 0, "underflow_hold");
        exp_at(1, SelErr, 1, "underflow_err");
        step(1);
        i_rd_cpl_done = 1'b0;
        exp_at(2, SelErr, 1, "err_sticky");
        step(3);
        reset = 1'b1;
        exp_at(1, SelErr, 0, "reset_clr_err");
        step(1);
        reset = 1'b0;
        step(1);

        // Overflow: 9 issues against a limit of 8
        i_rd_issue = 1'b1;
        exp_at(8, SelCnt, 8, "ovf_cnt_max");
        exp_at(8, SelErr, 0, "ovf_err_pre");
        exp_at(9, SelCnt, 8, "ovf_hold");
        exp_at(9, SelErr, 1, "ovf_err");
        step(9);
        i_rd_issue = 1'b0;
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(1);

        // Timeout: one read never completes
        i_rd_issue = 1'b1;
        step(1);
        i_rd_issue  = 1'b0;
        i_flush_req = 1'b1;
        exp_at(16, SelDone, 0, "tmo_done_early");
        exp_at(16, SelTmo, 0, "tmo_flag_early");
        exp_at(17, SelDone, 1, "tmo_done");
        exp_at(17, SelTmo, 1, "tmo_flag");
        exp_at(17, SelCnt, 1, "tmo_cnt_held");
        exp_done(17);
        step(19);
        i_flush_req = 1'b0;
        exp_at(1, SelCnt, 0, "tmo_cnt_clr");
        exp_at(1, SelTmo, 1, "tmo_sticky");
        exp_at(1, SelDone, 0, "tmo_done_drop");
        step(3);

        // Abort from DRAIN; the new flush also clears the timeout flag
        i_rd_issue  = 1'b1;
        i_flush_req = 1'b1;
        exp_at(1, SelTmo, 0, "tmo_clr_on_block");
        exp_at(1, SelCnt, 1, "abort_cnt1");
        step(1);
        i_rd_issue = 1'b0;
        step(2);
        i_flush_req = 1'b0;
        exp_at(1, SelBlock, 0, "abort_block");
        exp_at(1, SelDone, 0, "abort_no_done1");
        exp_at(2, SelDone, 0, "abort_no_done2");
        step(1);
        i_rd_cpl_done = 1'b1;
        step(1);
        i_rd_cpl_done = 1'b0;
        step(1);

        // Reset while in DONE
        i_flush_req = 1'b1;
        exp_at(3, SelDone, 1, "pre_rst_done");
        exp_done(3);
        step(4);
        exp_at(0, SelBlock, 1, "pre_rst_block");
        reset = 1'b1;
        exp_all_zero(1, "rst_in_done");
        step(1);
        reset       = 1'b0;
        i_flush_req = 1'b0;
        step(3);

        checks++;
        if (exp_q.size() != 0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d entries left, want 0/0",
                     exp_q.size(), done_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
